// File: rtl/gray_monitor.sv
// Consumer of a 3-bit Gray counter: converts sampled codes to binary, checks each
// step for legality, counts laps and sequence errors, and latches upstream overflow.
module gray_monitor #(
   parameter int LAP_W = 8,
   parameter int ERR_W = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Valid,
   input  logic [2:0]       GrayIn,
   input  logic             OvfIn,
   input  logic             Clear,
   output logic [2:0]       Binary,
   output logic             SampleOut,
   output logic             Wrap,
   output logic [LAP_W-1:0] Lap,
   output logic             Error,
   output logic [ERR_W-1:0] ErrCount,
   output logic             OvfSeen
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [2:0]       prev_r, prev_nxt_s;
   logic             sample_r, sample_nxt_s;
   logic             wrap_r, wrap_nxt_s;
   logic [LAP_W-1:0] lap_r, lap_nxt_s;
   logic             err_r, err_nxt_s;
   logic [ERR_W-1:0] ecnt_r, ecnt_nxt_s;
   logic             ovf_r, ovf_nxt_s;
   logic [2:0]       bin_s;
   logic [2:0]       prev_inc_s;

   function automatic logic [2:0] gray_to_bin(input logic [2:0] g);
      logic [2:0] b;
      b[2] = g[2];
      b[1] = g[2] ^ g[1];
      b[0] = g[2] ^ g[1] ^ g[0];
      return b;
   endfunction

   assign bin_s      = gray_to_bin(GrayIn);
   assign prev_inc_s = prev_r + 3'd1;

   // Next-state and next-output logic; Clear outranks a simultaneous sample.
   always_comb begin
      state_nxt_s  = state_r;
      prev_nxt_s   = prev_r;
      sample_nxt_s = 1'b0;
      wrap_nxt_s   = 1'b0;
      lap_nxt_s    = lap_r;
      err_nxt_s    = err_r;
      ecnt_nxt_s   = ecnt_r;
      ovf_nxt_s    = ovf_r;
      if (Clear) begin
         state_nxt_s = IDLE;
         prev_nxt_s  = 3'd0;
         lap_nxt_s   = {LAP_W{1'b0}};
         err_nxt_s   = 1'b0;
         ecnt_nxt_s  = {ERR_W{1'b0}};
         ovf_nxt_s   = 1'b0;
      end else if (Valid) begin
         sample_nxt_s = 1'b1;
         ovf_nxt_s    = ovf_r | OvfIn;
         case (state_r)
            IDLE: begin
               prev_nxt_s  = bin_s;
               state_nxt_s = TRACK;
            end
            TRACK, FAULT: begin
               if (bin_s == prev_r) begin
                  state_nxt_s = TRACK;
               end else if (bin_s == prev_inc_s) begin
                  prev_nxt_s  = bin_s;
                  state_nxt_s = TRACK;
                  // Only a 7->0 step can land here with prev at 7.
                  if (prev_r == 3'd7) begin
                     wrap_nxt_s = 1'b1;
                     if (lap_r != {LAP_W{1'b1}}) begin
                        lap_nxt_s = lap_r + {{(LAP_W-1){1'b0}}, 1'b1};
                     end else begin
                        lap_nxt_s = lap_r;
                     end
                  end else begin
                     wrap_nxt_s = 1'b0;
                  end
               end else begin
                  prev_nxt_s  = bin_s;
                  state_nxt_s = FAULT;
                  err_nxt_s   = 1'b1;
                  if (ecnt_r != {ERR_W{1'b1}}) begin
                     ecnt_nxt_s = ecnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
                  end else begin
                     ecnt_nxt_s = ecnt_r;
                  end
               end
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State and output registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_r  <= IDLE;
         prev_r   <= 3'd0;
         sample_r <= 1'b0;
         wrap_r   <= 1'b0;
         lap_r    <= {LAP_W{1'b0}};
         err_r    <= 1'b0;
         ecnt_r   <= {ERR_W{1'b0}};
         ovf_r    <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         prev_r   <= prev_nxt_s;
         sample_r <= sample_nxt_s;
         wrap_r   <= wrap_nxt_s;
         lap_r    <= lap_nxt_s;
         err_r    <= err_nxt_s;
         ecnt_r   <= ecnt_nxt_s;
         ovf_r    <= ovf_nxt_s;
      end
   end

   assign Binary    = prev_r;
   assign SampleOut = sample_r;
   assign Wrap      = wrap_r;
   assign Lap       = lap_r;
   assign Error     = err_r;
   assign ErrCount  = ecnt_r;
   assign OvfSeen   = ovf_r;

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor: a default-width instance plus a LAP_W=2 instance
// share stimulus; expected outputs are queued per driven cycle and compared after the edge.
module tb_gray_monitor;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Valid = 1'b0;
   logic [2:0] GrayIn = 3'd0;
   logic       OvfIn = 1'b0;
   logic       Clear = 1'b0;

   logic [2:0] Binary, Binary2;
   logic       SampleOut, SampleOut2, Wrap, Wrap2, Error, Error2, OvfSeen, OvfSeen2;
   logic [7:0] Lap;
   logic [1:0] Lap2;
   logic [3:0] ErrCount, ErrCount2;

   int total = 0;
   int bad   = 0;

   gray_monitor dut (
      .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn), .OvfIn(OvfIn), .Clear(Clear),
      .Binary(Binary), .SampleOut(SampleOut), .Wrap(Wrap), .Lap(Lap), .Error(Error),
      .ErrCount(ErrCount), .OvfSeen(OvfSeen)
   );

   gray_monitor #(.LAP_W(2), .ERR_W(4)) dut_sat (
      .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn), .OvfIn(OvfIn), .Clear(Clear),
      .Binary(Binary2), .SampleOut(SampleOut2), .Wrap(Wrap2), .Lap(Lap2), .Error(Error2),
      .ErrCount(ErrCount2), .OvfSeen(OvfSeen2)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int binary;
      int sample;
      int wrap;
      int lap;
      int lap_sat;
      int err;
      int ecnt;
      int ovf;
   } exp_t;

   exp_t exp_q[$];

   int m_state, m_prev, m_lap, m_err, m_ecnt, m_ovf;

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int bin_of(input int g);
      int r;
      r = 0;
      for (int k = 0; k < 8; k++) begin
         if ((k ^ (k >> 1)) == g) r = k;
      end
      return r;
   endfunction

   function automatic int gray_of(input int b);
      return (b ^ (b >> 1)) & 7;
   endfunction

   task automatic model_reset();
      m_state = 0; m_prev = 0; m_lap = 0; m_err = 0; m_ecnt = 0; m_ovf = 0;
   endtask

   // Called at a negedge: drive, predict, push, then compare after the posedge.
   task automatic step(input int v, input int g, input int ovf, input int clr, input string tag);
      exp_t e, o;
      int b;
      Valid  = v[0];
      GrayIn = g[2:0];
      OvfIn  = ovf[0];
      Clear  = clr[0];
      e.sample = 0;
      e.wrap   = 0;
      if (clr != 0) begin
         model_reset();
      end else if (v != 0) begin
         b = bin_of(g);
         m_ovf = m_ovf | ovf;
         e.sample = 1;
         if (m_state == 0) begin
            m_prev = b; m_state = 1;
         end else if (b == m_prev) begin
            m_state = 1;
         end else if (b == ((m_prev + 1) % 8)) begin
            if (m_prev == 7) begin
               e.wrap = 1; m_lap++;
            end
            m_prev = b; m_state = 1;
         end else begin
            m_err = 1; m_ecnt++; m_prev = b; m_state = 2;
         end
      end
      e.binary  = m_prev;
      e.lap     = (m_lap > 255) ? 255 : m_lap;
      e.lap_sat = (m_lap > 3) ? 3 : m_lap;
      e.err     = m_err;
      e.ecnt    = (m_ecnt > 15) ? 15 : m_ecnt;
      e.ovf     = m_ovf;
      exp_q.push_back(e);
      @(posedge Clk);
      #1;
      o = exp_q.pop_front();
      check_val({tag, ".binary"}, int'(Binary), o.binary);
      check_val({tag, ".sample"}, int'(SampleOut), o.sample);
      check_val({tag, ".wrap"}, int'(Wrap), o.wrap);
      check_val({tag, ".lap"}, int'(Lap), o.lap);
      check_val({tag, ".lap_sat"}, int'(Lap2), o.lap_sat);
      check_val({tag, ".error"}, int'(Error), o.err);
      check_val({tag, ".errcount"}, int'(ErrCount), o.ecnt);
      check_val({tag, ".errcount_sat"}, int'(ErrCount2), o.ecnt);
      check_val({tag, ".ovfseen"}, int'(OvfSeen), o.ovf);
      @(negedge Clk);
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, ".binary"}, int'(Binary), 0);
      check_val({tag, ".sample"}, int'(SampleOut), 0);
      check_val({tag, ".wrap"}, int'(Wrap), 0);
      check_val({tag, ".lap"}, int'(Lap), 0);
      check_val({tag, ".error"}, int'(Error), 0);
      check_val({tag, ".errcount"}, int'(ErrCount), 0);
      check_val({tag, ".ovfseen"}, int'(OvfSeen), 0);
   endtask

   initial begin
      model_reset();
      #12;
      check_zero("reset");
      @(negedge Clk);
      Reset = 1'b1;

      // legal full lap 0..7,0
      for (int k = 0; k <= 8; k++) step(1, gray_of(k % 8), 0, 0, "lap");
      // hold: 001 then 011 three times
      step(1, 3'b001, 0, 0, "hold_a");
      for (int k = 0; k < 3; k++) step(1, 3'b011, 0, 0, "hold_b");
      // idle cycles hold everything
      for (int k = 0; k < 2; k++) step(0, 3'b110, 1, 0, "novalid");
      // illegal jump 2->0, 0->4, then legal 4->5
      step(1, 3'b000, 0, 0, "ill_a");
      step(1, 3'b110, 0, 0, "ill_b");
      step(1, 3'b111, 0, 0, "ill_recover");

      // saturation: five laps, then twenty illegal steps
      step(0, 0, 0, 1, "clr1");
      step(1, 0, 0, 0, "sat_start");
      for (int k = 1; k <= 40; k++) step(1, gray_of(k % 8), 0, 0, "sat_lap");
      for (int k = 0; k < 20; k++) step(1, (k % 2 == 0) ? 3'b110 : 3'b000, 0, 0, "sat_err");

      // Clear together with Valid after Lap=2 and Error=1
      step(0, 0, 0, 1, "clr2");
      step(1, 0, 0, 0, "cv_start");
      for (int k = 1; k <= 16; k++) step(1, gray_of(k % 8), 0, 0, "cv_lap");
      step(1, 3'b111, 0, 0, "cv_ill");
      step(1, 3'b001, 0, 1, "cv_clear");
      step(1, 3'b011, 0, 0, "cv_idle_sample");

      // async reset mid-cycle during a lap
      step(1, gray_of(3), 0, 0, "ar_a");
      step(1, gray_of(4), 0, 0, "ar_b");
      #2;
      Reset = 1'b0;
      #1;
      check_zero("async_reset");
      model_reset();
      @(negedge Clk);
      Reset = 1'b1;

      // overflow: ignored without Valid, sticky once sampled
      step(0, 0, 1, 0, "ovf_novalid");
      step(1, 0, 1, 0, "ovf_set");
      step(1, 1, 0, 0, "ovf_hold_a");
      step(1, 3, 0, 0, "ovf_hold_b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gray_monitor.md
# gray_monitor

Downstream consumer of the 3-bit Gray-code counter. It samples the counter's Gray output whenever a sample strobe is asserted and converts it to binary. It checks that every step is a legal Gray-sequence step, counts completed laps (7→0 wraps), and flags and counts sequence errors. It sits between the counter and the status/display logic, giving them a binary value plus health information.

## Interface
- LAP_W, 8, width of the lap counter (saturating)
- ERR_W, 4, width of the error counter (saturating)
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset (0 = reset)
- Valid  input  1  sample strobe; GrayIn is captured on a rising Clk edge with Valid=1
- GrayIn  input  3  Gray code from the upstream counter
- OvfIn  input  1  upstream Overflow flag (level)
- Clear  input  1  synchronous clear of counters, Error and tracking state
- Binary  output  3  binary value of the last accepted sample
- SampleOut  output  1  one-cycle pulse: Binary/Lap/Error updated this cycle
- Wrap  output  1  one-cycle pulse on a legal 7→0 step
- Lap  output  LAP_W  number of legal 7→0 wraps, saturating at all-ones
- Error  output  1  sticky; set on any illegal step, cleared only by Reset or Clear
- ErrCount  output  ERR_W  number of illegal steps, saturating at all-ones
- OvfSeen  output  1  sticky; set on the first sampled OvfIn=1

## Operation
- Conversion: b[2]=g[2]; b[1]=g[2]^g[1]; b[0]=b[1]^g[0].
- Internal register Prev[2:0] holds the binary value of the last accepted sample.
- State machine: IDLE, TRACK, FAULT. Reset and Clear both go to IDLE.
- IDLE, Valid=1:
  - Prev, Binary ← converted value.
  - SampleOut=1; no check; go to TRACK.
- TRACK, Valid=1, new value B:
  - B == Prev: legal hold. Binary unchanged; SampleOut=1.
  - B == Prev+1 mod 8: legal step. Binary, Prev ← B; SampleOut=1.
    - If Prev=7 and B=0: Wrap=1 and Lap increments (saturating).
  - Any other B: illegal step.
    - Error ← 1; ErrCount increments (saturating).
    - Binary, Prev ← B (resync); SampleOut=1; go to FAULT.
- FAULT, Valid=1:
  - Same checks as TRACK.
  - A legal step or hold returns to TRACK.
  - An illegal step stays in FAULT and increments ErrCount.
  - Error remains 1 in both cases.
- OvfIn: sampled only when Valid=1; OvfSeen ← OvfSeen | OvfIn.
- Valid=0: state, Prev and all outputs hold; SampleOut and Wrap are 0.
- Clear=1 (synchronous):
  - Lap, ErrCount, Error, OvfSeen, Binary, Prev ← 0; state ← IDLE.
  - Clear has priority over a simultaneous Valid; that sample is discarded.
- Arithmetic: Prev+1 is computed in 3 bits, so 7+1=0. Counters never wrap; they stick at 2^W−1.

## Timing
- Reset asserted (Reset=0), asynchronously and immediately:
  - Binary=000, SampleOut=0, Wrap=0, Lap=0, Error=0, ErrCount=0, OvfSeen=0.
  - State IDLE, Prev=000.
- Reset deassertion is synchronised by the user. The first edge after release with Valid=1 is treated as an IDLE sample.
- Latency: GrayIn sampled at edge N appears on Binary/Lap/Error/ErrCount after edge N. SampleOut and Wrap are high for the cycle after edge N only.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Back-to-back Valid every cycle is supported with no bubbles.
- Reset mid-operation discards the sample in flight; no partial update.

## Test plan
- Legal full lap:
  - Stimulus: Reset, then Valid each cycle with GrayIn 000,001,011,010,110,111,101,100,000.
  - Response: Binary 0,1,2,3,4,5,6,7,0; Wrap pulses once, on the final sample; Lap=1; Error=0; ErrCount=0.
- Hold: GrayIn 011 sampled three times after 001 → Binary=2 throughout; Error=0.
- Illegal jump:
  - Stimulus: 000 then 110.
  - Response: Error=1, ErrCount=1, Binary=4, state FAULT.
  - Stimulus continues: next sample 111 → state TRACK, Binary=5, Error stays 1.
- Saturation:
  - With LAP_W=2: drive 5 full laps → Lap=3.
  - With ERR_W=4: drive 20 illegal steps → ErrCount=15.
- Clear and Valid together: after Lap=2, Error=1, assert Clear and Valid with GrayIn=001 → all counters 0, Error=0, SampleOut=0, state IDLE.
- Async reset and overflow:
  - Assert Reset=0 mid-cycle during a lap → outputs go to 0 before the next edge.
  - After release, sample OvfIn=1 with Valid → OvfSeen=1 and stays 1 after OvfIn returns to 0.
